// File: rtl/pkt_pkg.sv
// Shared types and flit encodings for the packet receiver.
package pkt_pkg;
    localparam int PKTW = 9;
    localparam logic ASSERT = 1'b1;
    localparam logic NEGATE = 1'b0;

    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DROP
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;
endpackage

// File: rtl/pkt_rx_if.sv
// Host-side read stream of the packet receiver.
interface pkt_rx_if;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_valid;
    logic       rd_ready;

    modport master (output rd_data, rd_last, rd_valid, input rd_ready);
    modport slave  (input rd_data, rd_last, rd_valid, output rd_ready);
endinterface

// File: rtl/pkt_fifo.sv
// Byte FIFO with a commit pointer; only committed bytes are visible to the reader.
module pkt_fifo
    import pkt_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   wr_en,
    input  entry_t wr_entry,
    input  logic   commit,
    input  logic   rewind,
    input  logic   rd_en,
    output logic   full,
    output logic   empty,
    output entry_t rd_entry
);
    localparam int AW = $clog2(DEPTH);

    entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] cm_ptr;
    logic [AW:0] rd_ptr;

    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (cm_ptr == rd_ptr);
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // Rewind drops only the uncommitted tail of the buffer
            if (rewind) begin
                wr_ptr <= cm_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (commit)
                    cm_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/pkt_rx.sv
// Packet receiver: frames switch flits into a store-and-forward byte FIFO.
module pkt_rx
    import pkt_pkg::*;
#(
    parameter logic [1:0] PORT   = 2'd0,
    parameter int         DEPTH  = 16,
    parameter int         MAXLEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PKTW:0]   flit_i,
    pkt_rx_if.master        rd,
    output logic [3:0]      pkt_cnt,
    output logic [7:0]      err_cnt,
    output logic [7:0]      drop_cnt
);
    state_t     state, nxt;
    logic [7:0] len, len_nxt;
    logic       wr_en, commit, rewind, last;
    logic       err_inc, drop_inc;
    logic       full, empty, rd_en;
    logic [1:0] ftype;
    entry_t     rd_entry;

    assign ftype = flit_i[9:8];

    pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_entry ({last, flit_i[7:0]}),
        .commit   (commit),
        .rewind   (rewind),
        .rd_en    (rd_en),
        .full     (full),
        .empty    (empty),
        .rd_entry (rd_entry)
    );

    assign rd.rd_valid = !empty;
    assign rd.rd_data  = rd_entry.data;
    assign rd.rd_last  = rd_entry.last;
    assign rd_en       = rd.rd_valid && rd.rd_ready;

    always_comb begin
        nxt      = state;
        len_nxt  = len;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        last     = 1'b0;
        err_inc  = 1'b0;
        drop_inc = 1'b0;
        unique case (state)
            S_IDLE, S_DROP: begin
                if (ftype == FT_HEAD) begin
                    if (flit_i[1:0] != PORT) begin
                        err_inc = 1'b1;
                        nxt     = S_IDLE;
                    end else if (full) begin
                        rewind   = 1'b1;
                        drop_inc = 1'b1;
                        nxt      = S_DROP;
                    end else begin
                        wr_en   = 1'b1;
                        len_nxt = 8'd1;
                        nxt     = S_RECV;
                    end
                end else if (ftype != FT_IDLE) begin
                    if (state == S_IDLE)
                        err_inc = 1'b1;
                    else if (ftype == FT_TAIL)
                        nxt = S_IDLE;
                end
            end
            S_RECV: begin
                if (ftype == FT_HEAD) begin
                    rewind  = 1'b1;
                    err_inc = 1'b1;
                    nxt     = S_IDLE;
                end else if (ftype != FT_IDLE) begin
                    if (len >= 8'(MAXLEN)) begin
                        rewind  = 1'b1;
                        err_inc = 1'b1;
                        nxt     = S_DROP;
                    end else if (full) begin
                        rewind   = 1'b1;
                        drop_inc = 1'b1;
                        nxt      = (ftype == FT_TAIL) ? S_IDLE : S_DROP;
                    end else begin
                        wr_en   = 1'b1;
                        len_nxt = len + 8'd1;
                        if (ftype == FT_TAIL) begin
                            last   = 1'b1;
                            commit = 1'b1;
                            nxt    = S_IDLE;
                        end
                    end
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state <= nxt;
            len   <= len_nxt;
            if ((wr_en && commit) != (rd_en && rd.rd_last)) begin
                if (wr_en && commit)
                    pkt_cnt <= pkt_cnt + 4'd1;
                else
                    pkt_cnt <= pkt_cnt - 4'd1;
            end
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (drop_inc && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_pkt_rx.sv
// Self-checking bench for pkt_rx with PORT=1: vector table plus corner sequences.
module tb_pkt_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] flit = '0;
    logic [3:0] pkt_cnt;
    logic [7:0] err_cnt;
    logic [7:0] drop_cnt;

    pkt_rx_if bus ();

    pkt_rx #(.PORT(2'd1), .DEPTH(16), .MAXLEN(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .flit_i   (flit),
        .rd       (bus.master),
        .pkt_cnt  (pkt_cnt),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int nchecks = 0;
    int nread = 0;
    int maxp = 0;
    logic toggle_en = 1'b0;
    logic [8:0] q [$];

    typedef struct packed {
        logic [0:3][9:0] f;
        logic [0:3][7:0] b;
        logic [2:0]      nb;
        logic [7:0]      e_err;
        logic [3:0]      e_pkt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rd_valid && bus.rd_ready) begin
            nread++;
            nchecks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got=%0h want=none",
                         {bus.rd_last, bus.rd_data});
            end else begin
                logic [8:0] e;
                e = q.pop_front();
                if ({bus.rd_last, bus.rd_data} != e) begin
                    errors++;
                    $display("FAIL rd_byte got=%0h want=%0h",
                             {bus.rd_last, bus.rd_data}, e);
                end
            end
        end
        if (int'(pkt_cnt) > maxp)
            maxp = int'(pkt_cnt);
    end

    always @(posedge clk) begin
        if (toggle_en)
            #2 bus.rd_ready = ~bus.rd_ready;
    end

    task automatic send(input logic [9:0] f);
        flit = f;
        @(posedge clk);
        #1;
        flit = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flit = '0;
        idle(2);
        q.delete();
        rst = 1'b0;
        idle(1);
    endtask

    task automatic wait_drain(input string name, input int lim);
        for (int c = 0; c < lim && q.size() != 0; c++)
            @(posedge clk);
        #1;
        chk(name, q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{f: '{10'h201, 10'h322, 10'h0, 10'h0},
                   b: '{8'h01, 8'h22, 8'h0, 8'h0}, nb: 3'd2,
                   e_err: 8'd0, e_pkt: 4'd1};
        tbl[1] = '{f: '{10'h202, 10'h333, 10'h0, 10'h0},
                   b: '0, nb: 3'd0, e_err: 8'd2, e_pkt: 4'd0};
        tbl[2] = '{f: '{10'h110, 10'h0, 10'h0, 10'h0},
                   b: '0, nb: 3'd0, e_err: 8'd1, e_pkt: 4'd0};
        tbl[3] = '{f: '{10'h205, 10'h144, 10'h209, 10'h355},
                   b: '0, nb: 3'd0, e_err: 8'd2, e_pkt: 4'd0};
        tbl[4] = '{f: '{10'h20D, 10'h0, 10'h166, 10'h377},
                   b: '{8'h0D, 8'h66, 8'h77, 8'h0}, nb: 3'd3,
                   e_err: 8'd0, e_pkt: 4'd1};
        tbl[5] = '{f: '{10'h200, 10'h0, 10'h0, 10'h0},
                   b: '0, nb: 3'd0, e_err: 8'd1, e_pkt: 4'd0};
        tbl[6] = '{f: '{10'h301, 10'h0, 10'h0, 10'h0},
                   b: '0, nb: 3'd0, e_err: 8'd1, e_pkt: 4'd0};
        tbl[7] = '{f: '0, b: '0, nb: 3'd0, e_err: 8'd0, e_pkt: 4'd0};
        tbl[8] = '{f: '{10'h281, 10'h182, 10'h183, 10'h384},
                   b: '{8'h81, 8'h82, 8'h83, 8'h84}, nb: 3'd4,
                   e_err: 8'd0, e_pkt: 4'd1};
        tbl[9] = '{f: '{10'h211, 10'h312, 10'h313, 10'h0},
                   b: '{8'h11, 8'h12, 8'h0, 8'h0}, nb: 3'd2,
                   e_err: 8'd1, e_pkt: 4'd1};

        bus.rd_ready = 1'b0;
        do_reset();
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_drop", drop_cnt, 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            bus.rd_ready = 1'b0;
            for (int j = 0; j < int'(tbl[i].nb); j++)
                q.push_back({(j == int'(tbl[i].nb) - 1), tbl[i].b[j]});
            for (int j = 0; j < 4; j++)
                send(tbl[i].f[j]);
            idle(1);
            chk($sformatf("v%0d_err", i), err_cnt, tbl[i].e_err);
            chk($sformatf("v%0d_pkt", i), pkt_cnt, tbl[i].e_pkt);
            chk($sformatf("v%0d_drop", i), drop_cnt, 0);
            bus.rd_ready = 1'b1;
            wait_drain($sformatf("v%0d_drain", i), 20);
            idle(1);
            chk($sformatf("v%0d_empty", i), bus.rd_valid, 0);
            chk($sformatf("v%0d_pkt0", i), pkt_cnt, 0);
            bus.rd_ready = 1'b0;
        end

        // Basic packet streaming back to back after the tail
        do_reset();
        bus.rd_ready = 1'b1;
        q.push_back(9'h001);
        q.push_back(9'h000);
        q.push_back(9'h001);
        q.push_back(9'h102);
        send(10'h201);
        send(10'h100);
        send(10'h101);
        chk("s1_prevalid", bus.rd_valid, 0);
        send(10'h302);
        chk("s1_valid", bus.rd_valid, 1);
        chk("s1_first", bus.rd_data, 8'h01);
        chk("s1_pkt1", pkt_cnt, 1);
        idle(4);
        chk("s1_pkt0", pkt_cnt, 0);
        chk("s1_done", q.size(), 0);
        chk("s1_empty", bus.rd_valid, 0);

        // Overlong packet goes to DROP, then back to IDLE at the tail
        do_reset();
        bus.rd_ready = 1'b0;
        send(10'h100);
        send(10'h201);
        for (int i = 0; i < 9; i++)
            send(10'h110 + 10'(i));
        send(10'h3FF);
        chk("s2_err", err_cnt, 2);
        chk("s2_pkt", pkt_cnt, 0);
        chk("s2_valid", bus.rd_valid, 0);
        q.push_back(9'h001);
        q.push_back(9'h15A);
        send(10'h201);
        send(10'h35A);
        chk("s2_after", pkt_cnt, 1);
        bus.rd_ready = 1'b1;
        wait_drain("s2_drain", 20);

        // Overflow: five packets fit, the sixth is dropped
        do_reset();
        bus.rd_ready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            logic [7:0] hb;
            hb = 8'(p << 4);
            if (p < 5) begin
                q.push_back({1'b0, hb | 8'h01});
                q.push_back({1'b0, hb | 8'h02});
                q.push_back({1'b1, hb | 8'h03});
            end
            send({2'b10, hb | 8'h01});
            send({2'b01, hb | 8'h02});
            send({2'b11, hb | 8'h03});
        end
        idle(1);
        chk("s3_pkt", pkt_cnt, 5);
        chk("s3_drop", drop_cnt, 1);
        chk("s3_err", err_cnt, 0);
        nread = 0;
        bus.rd_ready = 1'b1;
        wait_drain("s3_drain", 40);
        idle(2);
        chk("s3_nread", nread, 15);
        chk("s3_empty", bus.rd_valid, 0);

        // Reset in the middle of a packet
        do_reset();
        bus.rd_ready = 1'b1;
        send(10'h201);
        send(10'h122);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("s4_pkt", pkt_cnt, 0);
        chk("s4_err0", err_cnt, 0);
        chk("s4_drop", drop_cnt, 0);
        chk("s4_valid", bus.rd_valid, 0);
        send(10'h333);
        idle(1);
        chk("s4_err1", err_cnt, 1);
        chk("s4_nodata", bus.rd_valid, 0);

        // Two short packets while the reader toggles ready
        do_reset();
        bus.rd_ready = 1'b0;
        nread = 0;
        maxp = 0;
        q.push_back(9'h041);
        q.push_back(9'h142);
        q.push_back(9'h051);
        q.push_back(9'h152);
        toggle_en = 1'b1;
        send(10'h241);
        send(10'h342);
        send(10'h251);
        send(10'h352);
        wait_drain("s5_drain", 40);
        toggle_en = 1'b0;
        idle(2);
        bus.rd_ready = 1'b0;
        chk("s5_nread", nread, 4);
        chk("s5_maxpkt", int'(maxp > 2), 0);
        chk("s5_pkt0", pkt_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, nchecks);
        $finish;
    end
endmodule
